line_memory_responder: RTL and testbench
========================================

# line_memory_responder

Backing-store responder for the data cache. It serves line refills and line write-backs over a valid/ready request, write-data and response channel set. Fixed programmable access latency and word-serial bursts model main memory. It sits below the cache in the datapath memory hierarchy, on the far side of the cache's miss and eviction path.

## Interface
Parameters:
- DATA_WIDTH, 32, word width in bits.
- ADDR_WIDTH, 32, byte-address width.
- LINE_WORDS, 4, words per cache line; power of 2, ≥2.
- MEM_WORDS, 1024, storage depth in words; power of 2, multiple of LINE_WORDS.
- LATENCY, 4, wait cycles between request acceptance (read) or last write beat (write) and the first response; 0 allowed.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  high only in IDLE.
- req_we_i  in  1  1 = line write-back, 0 = line refill.
- req_addr_i  in  ADDR_WIDTH  byte address; low log2(LINE_WORDS)+2 bits ignored.
- wr_valid_i  in  1  write beat present.
- wr_ready_o  out  1  high only in WR_BURST.
- wr_data_i  in  DATA_WIDTH  write beat data.
- rsp_valid_o  out  1  response beat present.
- rsp_ready_i  in  1  cache accepts response beat.
- rsp_data_o  out  DATA_WIDTH  read beat data; 0 on write ack.
- rsp_last_o  out  1  final beat of response.
- rsp_err_o  out  1  out-of-range access (see Configuration).

## Operation
- Storage: MEM_WORDS × DATA_WIDTH array, asynchronous read. The array is not reset.
- Line base index: base = req_addr_i[ADDR_WIDTH-1:2] with the low log2(LINE_WORDS) bits cleared. Base and we are captured on acceptance.
- Beat counter k: log2(LINE_WORDS) bits, addresses word base+k.
- FSM states: IDLE, WR_BURST, WAIT, RD_BURST, WR_ACK.
- IDLE: on req_valid_i & req_ready_o, capture the request and clear k.
  - we=1: go to WR_BURST.
  - we=0: go to WAIT (or directly to RD_BURST if LATENCY=0).
- WR_BURST: each wr_valid_i & wr_ready_o writes wr_data_i to mem[base+k] and increments k.
  - On the beat with k=LINE_WORDS-1: go to WAIT (or WR_ACK if LATENCY=0).
- WAIT: latency counter runs 0..LATENCY-1, then exits to RD_BURST (read) or WR_ACK (write).
- RD_BURST: rsp_valid_o=1, rsp_data_o=mem[base+k], rsp_last_o=(k==LINE_WORDS-1).
  - k advances only on rsp_ready_i. Data must hold stable while stalled.
  - The last accepted beat returns the FSM to IDLE.
- WR_ACK: rsp_valid_o=1, rsp_last_o=1, rsp_data_o=0; go to IDLE on rsp_ready_i.
- Only one request is outstanding. A new request is not accepted in the cycle the previous response completes; the FSM must be in IDLE first.
- wr_valid_i outside WR_BURST is ignored. rsp_ready_i outside response states is ignored.

## Timing
- Reset (asynchronous assert, synchronous-to-clock release): state IDLE, k=0, latency counter 0, captured base/we=0.
  - Outputs after reset: req_ready_o=1, wr_ready_o=0, rsp_valid_o=0, rsp_data_o=0, rsp_last_o=0, rsp_err_o=0.
- Reset mid-burst aborts the transaction. Write beats already taken stay in memory; the remaining beats are not written.
- Read with no stalls: accept at cycle 0, first rsp_valid_o at cycle LATENCY+1, last beat at cycle LATENCY+LINE_WORDS.
- Write with no stalls: beats at cycles 1..LINE_WORDS, ack valid at cycle LINE_WORDS+LATENCY+1.
- Write and read of the same word in the same cycle cannot occur (the states are exclusive).
- All outputs are combinational decodes of registered state, k and the memory array.

## Configuration
- MEM_RANGE_CHECK_EN defined: a request is out of range when the byte address exceeds the storage size, i.e. req_addr_i[ADDR_WIDTH-1:2] ≥ MEM_WORDS. The out-of-range flag is captured on acceptance.
  - Out-of-range write: beats are still handshaken but dropped; the ack has rsp_err_o=1.
  - Out-of-range read: returns LINE_WORDS beats of data 0, each with rsp_err_o=1.
  - The handshake sequence is identical to an in-range access.
- Undefined: the index uses only the low log2(MEM_WORDS) word-address bits, so addresses wrap modulo MEM_WORDS. rsp_err_o is tied 0.

## Test plan
- Reset then idle: req_ready_o=1, rsp_valid_o=0 and wr_ready_o=0 for 10 cycles.
- Write then read, no stalls: write line at 0x40 with beats 0x11,0x22,0x33,0x44; ack at cycle 9 (LATENCY=4). Read 0x4C returns 0x11..0x44 at cycles 5..8, rsp_last_o on 0x44.
- Response backpressure: rsp_ready_i low for 3 cycles on beat 2. rsp_data_o holds 0x33, k does not advance, and the total burst lengthens by 3 cycles.
- Write beat gaps: wr_valid_i toggles every other cycle. All four words are written correctly, and WAIT starts only after the 4th beat.
- Reset asserted mid-read (beat 1) and mid-write (after 2 beats): FSM returns to IDLE, req_ready_o=1; for the write, words 0–1 hold the new data and words 2–3 the old data.
- Range: with the macro, read of address 0x1000 (MEM_WORDS=1024) gives 4 beats of 0 with rsp_err_o=1. Without the macro, the same read returns the line at 0x0000.

Source files
------------

// File: rtl/line_memory_responder_if.sv
// Request / write-data / response channel bundle between the data cache and
// its backing-store responder.
interface line_memory_responder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_we_i;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic                  wr_valid_i;
  logic                  wr_ready_o;
  logic [DATA_WIDTH-1:0] wr_data_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [DATA_WIDTH-1:0] rsp_data_o;
  logic                  rsp_last_o;
  logic                  rsp_err_o;

  modport master (
    output req_valid_i, req_we_i, req_addr_i, wr_valid_i, wr_data_i, rsp_ready_i,
    input  req_ready_o, wr_ready_o, rsp_valid_o, rsp_data_o, rsp_last_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, wr_valid_i, wr_data_i, rsp_ready_i,
    output req_ready_o, wr_ready_o, rsp_valid_o, rsp_data_o, rsp_last_o, rsp_err_o
  );
endinterface

// File: rtl/line_memory_responder.sv
// Main-memory model below the data cache: line refills / write-backs with fixed
// latency and word-serial bursts. Define MEM_RANGE_CHECK_EN to flag out-of-range lines.
module line_memory_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  parameter int MEM_WORDS  = 1024,
  parameter int LATENCY    = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  line_memory_responder_if.slave  bus
);

  localparam int KW = $clog2(LINE_WORDS);
  localparam int IW = $clog2(MEM_WORDS);
  localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WR_BURST = 3'd1;
  localparam logic [2:0] WAIT     = 3'd2;
  localparam logic [2:0] RD_BURST = 3'd3;
  localparam logic [2:0] WR_ACK   = 3'd4;

  typedef struct packed {
    logic          we;
    logic          oor;
    logic [IW-1:0] base;
  } req_t;

  logic [2:0]            state;
  logic [KW-1:0]         k;
  logic [LW-1:0]         lat_cnt;
  req_t                  req_q;
  logic                  req_oor;
  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic accept, wr_fire, rsp_fire, lat_done;

  assign accept   = bus.req_valid_i && (state == IDLE);
  assign wr_fire  = bus.wr_valid_i && (state == WR_BURST);
  assign rsp_fire = bus.rsp_ready_i && ((state == RD_BURST) || (state == WR_ACK));
  assign lat_done = (lat_cnt == LW'(LATENCY - 1));
  // Line base has its low KW bits cleared, so the beat index slots straight in.
  assign idx      = {req_q.base[IW-1:KW], k};

`ifdef MEM_RANGE_CHECK_EN
  assign req_oor = |bus.req_addr_i[ADDR_WIDTH-1:IW+2];
  logic unused_addr;
  assign unused_addr = ^bus.req_addr_i[KW+1:0];
`else
  // Upper word-address bits are dropped: accesses wrap modulo MEM_WORDS.
  assign req_oor = 1'b0;
  logic unused_addr;
  assign unused_addr = ^{bus.req_addr_i[ADDR_WIDTH-1:IW+2], bus.req_addr_i[KW+1:0]};
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      k       <= '0;
      lat_cnt <= '0;
      req_q   <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          req_q   <= '{we:   bus.req_we_i,
                       oor:  req_oor,
                       base: {bus.req_addr_i[IW+1:KW+2], {KW{1'b0}}}};
          k       <= '0;
          lat_cnt <= '0;
          if (bus.req_we_i)      state <= WR_BURST;
          else if (LATENCY == 0) state <= RD_BURST;
          else                   state <= WAIT;
        end
        WR_BURST: if (wr_fire) begin
          k <= k + 1'b1;
          if (&k) state <= (LATENCY == 0) ? WR_ACK : WAIT;
        end
        WAIT: begin
          if (lat_done) begin
            lat_cnt <= '0;
            state   <= req_q.we ? WR_ACK : RD_BURST;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        RD_BURST: if (rsp_fire) begin
          k <= k + 1'b1;
          if (&k) state <= IDLE;
        end
        WR_ACK: if (rsp_fire) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Storage is deliberately not reset; out-of-range beats are handshaken but dropped.
  always_ff @(posedge clk_i) begin
    if (wr_fire && !req_q.oor) mem[idx] <= bus.wr_data_i;
  end

  assign bus.req_ready_o = (state == IDLE);
  assign bus.wr_ready_o  = (state == WR_BURST);
  assign bus.rsp_valid_o = (state == RD_BURST) || (state == WR_ACK);
  assign bus.rsp_data_o  = ((state == RD_BURST) && !req_q.oor) ? mem[idx] : '0;
  assign bus.rsp_last_o  = ((state == RD_BURST) && (&k)) || (state == WR_ACK);
`ifdef MEM_RANGE_CHECK_EN
  assign bus.rsp_err_o   = bus.rsp_valid_o && req_q.oor;
`else
  assign bus.rsp_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_line_memory_responder.sv
// Scoreboard bench for line_memory_responder (LATENCY=4, LINE_WORDS=4, MEM_WORDS=1024);
// covers both builds of MEM_RANGE_CHECK_EN.
module tb_line_memory_responder;
  localparam int LAT = 4;

  logic clk;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        err;
  } rsp_t;
  rsp_t sb[$];

  line_memory_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  line_memory_responder #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .LINE_WORDS(4), .MEM_WORDS(1024), .LATENCY(LAT)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard consumer: every accepted response beat is checked in order.
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid_o && bus.rsp_ready_i) begin
      if (sb.size() == 0) chk("sb_unexpected", 1, 0);
      else begin
        rsp_t e;
        e = sb.pop_front();
        chk("rsp_data", bus.rsp_data_o, e.data);
        chk("rsp_last", bus.rsp_last_o, e.last);
        chk("rsp_err",  bus.rsp_err_o,  e.err);
      end
    end
  end

  task automatic do_write(input logic [31:0] addr, input logic [0:3][31:0] d,
                          input bit gap, input logic err);
    int beat = 0, cyc = 0, rdy = 0, lastb = 0, ackc = -1;
    @(posedge clk); #1;
    bus.req_valid_i = 1; bus.req_we_i = 1; bus.req_addr_i = addr;
    @(negedge clk); chk("wr_accept", bus.req_ready_o, 1);
    while (beat < 4 && cyc < 100) begin
      @(posedge clk); #1; cyc++;
      bus.req_valid_i = 0;
      bus.wr_valid_i  = gap ? cyc[0] : 1'b1;
      bus.wr_data_i   = d[beat];
      @(negedge clk);
      if (bus.wr_ready_o) rdy++;
      if (bus.wr_valid_i && bus.wr_ready_o) begin beat++; lastb = cyc; end
    end
    if (beat < 4) chk("wr_timeout", beat, 4);
    @(posedge clk); #1; cyc++; bus.wr_valid_i = 0;
    @(negedge clk);
    chk("wr_wait_ready", bus.wr_ready_o, 0);
    chk("wr_wait_rsp", bus.rsp_valid_o, 0);
    chk("wr_ready_cycles", rdy, gap ? 7 : 4);
    sb.push_back('{32'h0, 1'b1, err});
    bus.rsp_ready_i = 1;
    while (ackc < 0 && cyc < 200) begin
      @(posedge clk); #1; cyc++;
      @(negedge clk);
      if (bus.rsp_valid_o) ackc = cyc;
    end
    chk("wr_ack_cycle", ackc, lastb + LAT + 1);
    @(posedge clk); #1; bus.rsp_ready_i = 0;
    @(negedge clk); chk("wr_back_idle", bus.req_ready_o, 1);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [0:3][31:0] d,
                         input logic err, input int stall_beat, input int stall_n);
    int beat = 0, cyc = 0, first = -1, lastc = -1, st = 0;
    for (int i = 0; i < 4; i++) sb.push_back('{d[i], (i == 3), err});
    @(posedge clk); #1;
    bus.req_valid_i = 1; bus.req_we_i = 0; bus.req_addr_i = addr;
    @(negedge clk); chk("rd_accept", bus.req_ready_o, 1);
    while (beat < 4 && cyc < 100) begin
      @(posedge clk); #1; cyc++;
      bus.req_valid_i = 0;
      bus.rsp_ready_i = !(beat == stall_beat && st < stall_n);
      @(negedge clk);
      if (bus.rsp_valid_o) begin
        if (first < 0) first = cyc;
        if (bus.rsp_ready_i) begin lastc = cyc; beat++; end
        else begin st++; chk("stall_hold", bus.rsp_data_o, d[beat]); end
      end
    end
    if (beat < 4) chk("rd_timeout", beat, 4);
    chk("rd_first_cycle", first, LAT + 1);
    chk("rd_last_cycle", lastc, LAT + 4 + stall_n);
    @(posedge clk); #1; bus.rsp_ready_i = 0;
    @(negedge clk); chk("rd_back_idle", bus.req_ready_o, 1);
  endtask

  task automatic pulse_reset();
    rst_n = 0;
    #1;
    chk("rst_req_ready", bus.req_ready_o, 1);
    chk("rst_rsp_valid", bus.rsp_valid_o, 0);
    chk("rst_wr_ready",  bus.wr_ready_o, 0);
    @(negedge clk); rst_n = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int w;
    rst_n = 0;
    bus.req_valid_i = 0; bus.req_we_i = 0; bus.req_addr_i = '0;
    bus.wr_valid_i = 0; bus.wr_data_i = '0; bus.rsp_ready_i = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;

    // Idle with stray write beats and response-ready that must be ignored.
    bus.wr_valid_i = 1; bus.wr_data_i = 32'hDEAD_BEEF; bus.rsp_ready_i = 1;
    chk("rst_rsp_data", bus.rsp_data_o, 0);
    chk("rst_rsp_last", bus.rsp_last_o, 0);
    chk("rst_rsp_err",  bus.rsp_err_o, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_req_ready", bus.req_ready_o, 1);
      chk("idle_rsp_valid", bus.rsp_valid_o, 0);
      chk("idle_wr_ready",  bus.wr_ready_o, 0);
    end
    bus.wr_valid_i = 0; bus.rsp_ready_i = 0;

    do_write(32'h40, {32'h11, 32'h22, 32'h33, 32'h44}, 0, 0);
    do_read (32'h4C, {32'h11, 32'h22, 32'h33, 32'h44}, 0, -1, 0);
    do_read (32'h40, {32'h11, 32'h22, 32'h33, 32'h44}, 0, 2, 3);

    do_write(32'hC0, {32'h55, 32'h66, 32'h77, 32'h88}, 1, 0);
    do_read (32'hC4, {32'h55, 32'h66, 32'h77, 32'h88}, 0, -1, 0);

    // Reset while beat 1 of a refill is on the bus.
    sb.push_back('{32'h11, 1'b0, 1'b0});
    @(posedge clk); #1;
    bus.req_valid_i = 1; bus.req_we_i = 0; bus.req_addr_i = 32'h40; bus.rsp_ready_i = 0;
    @(posedge clk); #1; bus.req_valid_i = 0;
    w = 0;
    @(negedge clk);
    while (!bus.rsp_valid_o && w < 20) begin @(negedge clk); w++; end
    if (w >= 20) chk("mid_rd_timeout", w, 0);
    @(posedge clk); #1; bus.rsp_ready_i = 1;
    @(posedge clk); #1; bus.rsp_ready_i = 0;
    @(negedge clk); chk("mid_rd_beat1", bus.rsp_data_o, 32'h22);
    pulse_reset();

    // Reset after two of four write-back beats: old data survives in words 2-3.
    do_write(32'h80, {32'hA0, 32'hA1, 32'hA2, 32'hA3}, 0, 0);
    @(posedge clk); #1;
    bus.req_valid_i = 1; bus.req_we_i = 1; bus.req_addr_i = 32'h80;
    @(posedge clk); #1; bus.req_valid_i = 0; bus.wr_valid_i = 1; bus.wr_data_i = 32'hB0;
    @(posedge clk); #1; bus.wr_data_i = 32'hB1;
    @(posedge clk); #1; bus.wr_valid_i = 0;
    @(negedge clk); chk("mid_wr_ready", bus.wr_ready_o, 1);
    pulse_reset();
    do_read(32'h80, {32'hB0, 32'hB1, 32'hA2, 32'hA3}, 0, -1, 0);

    do_write(32'h0, {32'hC0, 32'hC1, 32'hC2, 32'hC3}, 0, 0);
`ifdef MEM_RANGE_CHECK_EN
    do_read (32'h1000, {32'h0, 32'h0, 32'h0, 32'h0}, 1, -1, 0);
    do_write(32'h1040, {32'hE0, 32'hE1, 32'hE2, 32'hE3}, 0, 1);
    do_read (32'h40, {32'h11, 32'h22, 32'h33, 32'h44}, 0, -1, 0);
`else
    do_read (32'h1000, {32'hC0, 32'hC1, 32'hC2, 32'hC3}, 0, -1, 0);
`endif

    repeat (2) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
